// File: rtl/nr1w_port_ram_pkg.sv
// Shared definitions for the multi-read single-write RAM: clear FSM encoding
// and the depth helper used by every bank.
package nr1w_port_ram_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    function automatic int unsigned ram_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/nr1w_port_ram_rw.sv
// One storage bank: a single write port and a single registered read port.
// Read-first on collision; the read register clears on reset.
module rw_port_ram
    import nr1w_port_ram_pkg::*;
#(
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 12,
    parameter string RAM_TYPE   = "auto"
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr_w,
    input  logic [DATA_WIDTH-1:0] data_w,
    input  logic [ADDR_WIDTH-1:0] addr_r,
    output logic [DATA_WIDTH-1:0] data_r
);

    localparam int unsigned DEPTH = ram_depth(ADDR_WIDTH);

    // Only the style attribute differs between branches.
    generate
        if (RAM_TYPE == "distributed") begin : g_dist
            (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (we) mem[addr_w] <= data_w;
            end

            always_ff @(posedge clk) begin
                if (!reset_n) data_r <= '0;
                else          data_r <= mem[addr_r];
            end
        end else if (RAM_TYPE == "block") begin : g_block
            (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (we) mem[addr_w] <= data_w;
            end

            always_ff @(posedge clk) begin
                if (!reset_n) data_r <= '0;
                else          data_r <= mem[addr_r];
            end
        end else begin : g_auto
            logic [DATA_WIDTH-1:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (we) mem[addr_w] <= data_w;
            end

            always_ff @(posedge clk) begin
                if (!reset_n) data_r <= '0;
                else          data_r <= mem[addr_r];
            end
        end
    endgenerate

endmodule

// File: rtl/nr1w_port_ram.sv
// NUM_READ-port / 1-write RAM built from replicated banks, with optional
// read-during-write bypass and a zero-fill clear engine.
module nr1w_port_ram
    import nr1w_port_ram_pkg::*;
#(
    parameter int    DATA_WIDTH     = 8,
    parameter int    ADDR_WIDTH     = 12,
    parameter int    NUM_READ       = 3,
    parameter int    BYPASS         = 1,
    parameter int    CLEAR_ON_RESET = 1,
    parameter string RAM_TYPE       = "auto"
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] addr_r,
    input  logic [ADDR_WIDTH-1:0]          addr_w,
    input  logic [DATA_WIDTH-1:0]          data_in,
    input  logic                           we,
    input  logic                           clear,
    output logic [NUM_READ*DATA_WIDTH-1:0] data_out,
    output logic                           busy
);

    logic [0:0]            state;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   cnt_nxt;
    logic                  ew;
    logic [ADDR_WIDTH-1:0] ewa;
    logic [DATA_WIDTH-1:0] ewd;
    logic [DATA_WIDTH-1:0] ewd_q;

    // The clear engine owns the write port while busy; nothing is written in reset.
    always_comb begin
        ew      = reset_n & (busy | we);
        ewa     = busy ? cnt[ADDR_WIDTH-1:0] : addr_w;
        ewd     = busy ? '0 : data_in;
        cnt_nxt = cnt + 1'b1;
    end

    // The MSB of the next count marks the last address as written this cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            cnt   <= '0;
            busy  <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    if (clear) begin
                        cnt <= '0;
                    end else if (cnt_nxt[ADDR_WIDTH]) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) ewd_q <= '0;
        else          ewd_q <= ewd;
    end

    generate
        for (genvar i = 0; i < NUM_READ; i++) begin : g_port
            logic [DATA_WIDTH-1:0] rd;
            logic                  hit_q;

            rw_port_ram #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .RAM_TYPE   (RAM_TYPE)
            ) u_bank (
                .clk     (clk),
                .reset_n (reset_n),
                .we      (ew),
                .addr_w  (ewa),
                .data_w  (ewd),
                .addr_r  (addr_r[i*ADDR_WIDTH +: ADDR_WIDTH]),
                .data_r  (rd)
            );

            // Registered collision flag keeps data_in off the data_out path.
            always_ff @(posedge clk) begin
                if (!reset_n) hit_q <= 1'b0;
                else          hit_q <= (BYPASS != 0) && ew &&
                                       (addr_r[i*ADDR_WIDTH +: ADDR_WIDTH] == ewa);
            end

            assign data_out[i*DATA_WIDTH +: DATA_WIDTH] = busy  ? '0    :
                                                          hit_q ? ewd_q : rd;
        end
    endgenerate

endmodule

// File: tb/tb_nr1w_port_ram.sv
// Directed bench for nr1w_port_ram: a BYPASS=1 and a BYPASS=0 instance share stimulus.
module tb_nr1w_port_ram;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NR = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NR*AW-1:0] addr_r;
    logic [AW-1:0]    addr_w;
    logic [DW-1:0]    data_in;
    logic             we;
    logic             clear;
    logic [NR*DW-1:0] data_out0;
    logic [NR*DW-1:0] data_out1;
    logic             busy0;
    logic             busy1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nr1w_port_ram #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR),
        .BYPASS(1), .CLEAR_ON_RESET(1), .RAM_TYPE("auto")
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .addr_r(addr_r), .addr_w(addr_w),
        .data_in(data_in), .we(we), .clear(clear), .data_out(data_out0), .busy(busy0)
    );

    nr1w_port_ram #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR),
        .BYPASS(0), .CLEAR_ON_RESET(1), .RAM_TYPE("auto")
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .addr_r(addr_r), .addr_w(addr_w),
        .data_in(data_in), .we(we), .clear(clear), .data_out(data_out1), .busy(busy1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [AW-1:0] a2);
        addr_r = {a2, a1, a0};
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1; addr_w = a; data_in = d;
        tick;
        we = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        bit zero_ok;
        reset_n = 1'b0; we = 1'b0; clear = 1'b0;
        addr_w = '0; data_in = '0; set_raddr(0, 0, 0);
        tick; tick;
        checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy got=%b/%b exp=1", busy0, busy1);
        end
        checks++;
        if (data_out0 !== '0) begin
            failures++;
            $display("FAIL reset_dout got=%h exp=0", data_out0);
        end
        reset_n = 1'b1;
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            n++;
            tick;
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL reset_busy_len got=%0d exp=16", n);
        end
        zero_ok = 1'b1;
        for (int a = 0; a < 16; a++) begin
            set_raddr(a[AW-1:0], a[AW-1:0], a[AW-1:0]);
            tick;
            if (data_out0 !== '0 || data_out1 !== '0) zero_ok = 1'b0;
        end
        checks++;
        if (!zero_ok) begin
            failures++;
            $display("FAIL reset_zero_fill got=nonzero exp=all_zero");
        end
    endtask

    task automatic test_write_read;
        write_word(4'd3, 8'hA5);
        set_raddr(3, 3, 3);
        tick;
        checks++;
        if (data_out0 !== {3{8'hA5}} || data_out1 !== {3{8'hA5}}) begin
            failures++;
            $display("FAIL write_read got=%h/%h exp=%h", data_out0, data_out1, {3{8'hA5}});
        end
    endtask

    task automatic test_bypass;
        write_word(4'd7, 8'hA5);
        we = 1'b1; addr_w = 4'd7; data_in = 8'h3C;
        set_raddr(0, 7, 0);
        tick;
        we = 1'b0;
        checks++;
        if (data_out0[15:8] !== 8'h3C) begin
            failures++;
            $display("FAIL bypass_new got=%h exp=3c", data_out0[15:8]);
        end
        checks++;
        if (data_out1[15:8] !== 8'hA5) begin
            failures++;
            $display("FAIL bypass_old got=%h exp=a5", data_out1[15:8]);
        end
        checks++;
        if (data_out0[7:0] !== 8'h00) begin
            failures++;
            $display("FAIL bypass_other_port got=%h exp=00", data_out0[7:0]);
        end
        tick;
        checks++;
        if (data_out0[15:8] !== 8'h3C || data_out1[15:8] !== 8'h3C) begin
            failures++;
            $display("FAIL bypass_after got=%h/%h exp=3c", data_out0[15:8], data_out1[15:8]);
        end
    endtask

    task automatic test_multi_port;
        write_word(4'd1, 8'h11);
        write_word(4'd2, 8'h22);
        write_word(4'd3, 8'h33);
        set_raddr(1, 2, 3);
        tick;
        checks++;
        if (data_out0 !== 24'h332211 || data_out1 !== 24'h332211) begin
            failures++;
            $display("FAIL multi_port got=%h/%h exp=332211", data_out0, data_out1);
        end
        // Boundary addresses 0 and 15
        write_word(4'd0, 8'h5A);
        write_word(4'd15, 8'hC3);
        set_raddr(15, 0, 15);
        tick;
        checks++;
        if (data_out0 !== 24'hC35AC3) begin
            failures++;
            $display("FAIL edge_addr got=%h exp=c35ac3", data_out0);
        end
    endtask

    task automatic test_clear_drop;
        int n;
        bit zero_ok;
        for (int a = 0; a < 16; a++) write_word(a[AW-1:0], 8'h40 + a[DW-1:0]);
        set_raddr(9, 9, 9);
        tick;
        checks++;
        if (data_out0 !== {3{8'h49}}) begin
            failures++;
            $display("FAIL fill got=%h exp=%h", data_out0, {3{8'h49}});
        end
        clear = 1'b1;
        tick;
        clear = 1'b0;
        set_raddr(5, 5, 5);
        n = 0;
        zero_ok = 1'b1;
        while (busy0 === 1'b1 && n < 100) begin
            if (data_out0 !== '0 || data_out1 !== '0) zero_ok = 1'b0;
            we = (n == 8); addr_w = 4'd5; data_in = 8'hFF;
            n++;
            tick;
        end
        we = 1'b0;
        checks++;
        if (n != 16 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL clear_busy_len got=%0d exp=16", n);
        end
        checks++;
        if (!zero_ok) begin
            failures++;
            $display("FAIL clear_dout_forced got=nonzero exp=0");
        end
        tick;
        checks++;
        if (data_out0 !== '0 || data_out1 !== '0) begin
            failures++;
            $display("FAIL clear_drop_we got=%h exp=0", data_out0);
        end
        set_raddr(9, 15, 0);
        tick;
        checks++;
        if (data_out0 !== '0) begin
            failures++;
            $display("FAIL clear_zeroed got=%h exp=0", data_out0);
        end
        // First external write accepted once busy is low
        write_word(4'd6, 8'h66);
        set_raddr(6, 6, 6);
        tick;
        checks++;
        if (data_out0 !== {3{8'h66}}) begin
            failures++;
            $display("FAIL post_clear_write got=%h exp=%h", data_out0, {3{8'h66}});
        end
    endtask

    task automatic test_reset_mid_clear;
        int n;
        write_word(4'd12, 8'h77);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        for (int k = 0; k < 8; k++) tick;
        reset_n = 1'b0;
        tick; tick;
        checks++;
        if (busy0 !== 1'b1) begin
            failures++;
            $display("FAIL midclear_reset_busy got=%b exp=1", busy0);
        end
        reset_n = 1'b1;
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            n++;
            tick;
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL midclear_restart_len got=%0d exp=16", n);
        end
        set_raddr(12, 6, 0);
        tick;
        checks++;
        if (data_out0 !== '0 || data_out1 !== '0) begin
            failures++;
            $display("FAIL midclear_zeroed got=%h/%h exp=0", data_out0, data_out1);
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_bypass;
        test_multi_port;
        test_clear_drop;
        test_reset_mid_clear;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
